wts_envelope_channel_sequencer: RTL and testbench

//  Owns the per-channel ADSR state (counter/state/level) and time-multiplexes the combinational

---
 rtl/wts_envelope_channel_sequencer.sv | 155 +++++++++++++++
 tb/tb_wts_envelope_channel_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_envelope_channel_sequencer.sv
// rtl/wts_envelope_channel_sequencer.sv - per-channel ADSR state storage, key-event latch and slot sequencer
module wts_envelope_channel_sequencer #(
    parameter int CHANNELS = 8,
    parameter int CH_BITS  = 3
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                slot_en,
    input  logic                key_on_req,
    input  logic                key_release_req,
    input  logic                key_off_req,
    input  logic [CH_BITS-1:0]  key_ch,
    output logic [CH_BITS-1:0]  eg_channel,
    output logic                eg_key_on,
    output logic                eg_key_release,
    output logic                eg_key_off,
    output logic [15:0]         eg_counter_in,
    output logic [2:0]          eg_state_in,
    output logic [7:0]          eg_level_in,
    input  logic [15:0]         eg_counter_out,
    input  logic [2:0]          eg_state_out,
    input  logic [7:0]          eg_level_out,
    output logic                level_valid,
    output logic [CH_BITS-1:0]  level_ch,
    output logic [7:0]          level
);

    // One extra bit so the range check also works when CHANNELS == 2**CH_BITS.
    localparam logic [CH_BITS:0]   CH_LIMIT  = (CH_BITS+1)'(CHANNELS);
    localparam logic [CH_BITS-1:0] LAST_SLOT = CH_BITS'(CHANNELS - 1);

    // Per-channel envelope storage
    logic [15:0]         counter_q   [CHANNELS];
    logic [15:0]         counter_d   [CHANNELS];
    logic [2:0]          state_q     [CHANNELS];
    logic [2:0]          state_d     [CHANNELS];
    logic [7:0]          lvl_store_q [CHANNELS];
    logic [7:0]          lvl_store_d [CHANNELS];

    // Latched key events, one bit per channel
    logic [CHANNELS-1:0] pend_on_q,  pend_on_d;
    logic [CHANNELS-1:0] pend_rel_q, pend_rel_d;
    logic [CHANNELS-1:0] pend_off_q, pend_off_d;

    // Pending flags with this cycle's request already folded in
    logic [CHANNELS-1:0] merged_on;
    logic [CHANNELS-1:0] merged_rel;
    logic [CHANNELS-1:0] merged_off;

    // Slot pointer and published level
    logic [CH_BITS-1:0]  slot_q,        slot_d;
    logic                level_valid_q, level_valid_d;
    logic [CH_BITS-1:0]  level_ch_q,    level_ch_d;
    logic [7:0]          level_pub_q,   level_pub_d;

    logic                req_ok;

    assign req_ok = ({1'b0, key_ch} < CH_LIMIT);

    // Fold the incoming request into the pending flags: on, then release, then off (off wins)
    always_comb begin
        merged_on  = pend_on_q;
        merged_rel = pend_rel_q;
        merged_off = pend_off_q;
        if (req_ok) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (key_ch == CH_BITS'(i)) begin
                    if (key_on_req) begin
                        merged_on[i]  = 1'b1;
                        merged_rel[i] = 1'b0;
                    end
                    if (key_release_req) begin
                        merged_rel[i] = 1'b1;
                    end
                    if (key_off_req) begin
                        merged_off[i] = 1'b1;
                        merged_on[i]  = 1'b0;
                        merged_rel[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Present the current slot's stored state and events to the step logic
    always_comb begin
        eg_channel     = slot_q;
        eg_counter_in  = counter_q[slot_q];
        eg_state_in    = state_q[slot_q];
        eg_level_in    = lvl_store_q[slot_q];
        eg_key_on      = slot_en & merged_on[slot_q];
        eg_key_release = slot_en & merged_rel[slot_q];
        eg_key_off     = slot_en & merged_off[slot_q];
    end

    // Next state: write back the serviced slot, consume its events, advance and publish
    always_comb begin
        counter_d     = counter_q;
        state_d       = state_q;
        lvl_store_d   = lvl_store_q;
        pend_on_d     = merged_on;
        pend_rel_d    = merged_rel;
        pend_off_d    = merged_off;
        slot_d        = slot_q;
        level_valid_d = 1'b0;
        level_ch_d    = level_ch_q;
        level_pub_d   = level_pub_q;
        if (slot_en) begin
            counter_d[slot_q]   = eg_counter_out;
            state_d[slot_q]     = eg_state_out;
            lvl_store_d[slot_q] = eg_level_out;
            pend_on_d[slot_q]   = 1'b0;
            pend_rel_d[slot_q]  = 1'b0;
            pend_off_d[slot_q]  = 1'b0;
            slot_d              = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
            level_valid_d       = 1'b1;
            level_ch_d          = slot_q;
            level_pub_d         = eg_level_out;
        end
    end

    // State registers; reset discards all stored state and pending events
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                counter_q[i]   <= '0;
                state_q[i]     <= '0;
                lvl_store_q[i] <= '0;
            end
            pend_on_q     <= '0;
            pend_rel_q    <= '0;
            pend_off_q    <= '0;
            slot_q        <= '0;
            level_valid_q <= 1'b0;
            level_ch_q    <= '0;
            level_pub_q   <= '0;
        end else begin
            counter_q     <= counter_d;
            state_q       <= state_d;
            lvl_store_q   <= lvl_store_d;
            pend_on_q     <= pend_on_d;
            pend_rel_q    <= pend_rel_d;
            pend_off_q    <= pend_off_d;
            slot_q        <= slot_d;
            level_valid_q <= level_valid_d;
            level_ch_q    <= level_ch_d;
            level_pub_q   <= level_pub_d;
        end
    end

    assign level_valid = level_valid_q;
    assign level_ch    = level_ch_q;
    assign level       = level_pub_q;

endmodule

// File: tb/tb_wts_envelope_channel_sequencer.sv
// tb/tb_wts_envelope_channel_sequencer.sv - scoreboard bench for the envelope channel sequencer
module tb_wts_envelope_channel_sequencer;

    logic        clk;
    logic        nreset;

    // 8-channel instance
    logic        slot_en, key_on_req, key_release_req, key_off_req;
    logic [2:0]  key_ch, eg_channel, level_ch;
    logic        eg_key_on, eg_key_release, eg_key_off, level_valid;
    logic [15:0] eg_counter_in, eg_counter_out;
    logic [2:0]  eg_state_in, eg_state_out;
    logic [7:0]  eg_level_in, eg_level_out, level;

    // 6-channel instance
    logic        slot_en6, key_on6, key_rel6, key_off6;
    logic [2:0]  key_ch6, eg_channel6, level_ch6;
    logic        eg_key_on6, eg_key_rel6, eg_key_off6, level_valid6;
    logic [15:0] eg_counter_in6, eg_counter_out6;
    logic [2:0]  eg_state_in6, eg_state_out6;
    logic [7:0]  eg_level_in6, eg_level_out6, level6;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model of the 8-channel instance
    logic [15:0] m_cnt  [8];
    logic [2:0]  m_st   [8];
    logic [7:0]  m_lvl  [8];
    logic [7:0]  m_pon, m_prel, m_poff;
    logic [2:0]  m_slot;
    logic [10:0] sb[$];

    // Model of the 6-channel instance
    logic [5:0]  m6_pon;
    logic [2:0]  m6_slot;
    logic [2:0]  sb6[$];

    wts_envelope_channel_sequencer #(.CHANNELS(8), .CH_BITS(3)) u_dut (
        .clk(clk), .nreset(nreset), .slot_en(slot_en),
        .key_on_req(key_on_req), .key_release_req(key_release_req), .key_off_req(key_off_req),
        .key_ch(key_ch), .eg_channel(eg_channel),
        .eg_key_on(eg_key_on), .eg_key_release(eg_key_release), .eg_key_off(eg_key_off),
        .eg_counter_in(eg_counter_in), .eg_state_in(eg_state_in), .eg_level_in(eg_level_in),
        .eg_counter_out(eg_counter_out), .eg_state_out(eg_state_out), .eg_level_out(eg_level_out),
        .level_valid(level_valid), .level_ch(level_ch), .level(level)
    );

    wts_envelope_channel_sequencer #(.CHANNELS(6), .CH_BITS(3)) u_dut6 (
        .clk(clk), .nreset(nreset), .slot_en(slot_en6),
        .key_on_req(key_on6), .key_release_req(key_rel6), .key_off_req(key_off6),
        .key_ch(key_ch6), .eg_channel(eg_channel6),
        .eg_key_on(eg_key_on6), .eg_key_release(eg_key_rel6), .eg_key_off(eg_key_off6),
        .eg_counter_in(eg_counter_in6), .eg_state_in(eg_state_in6), .eg_level_in(eg_level_in6),
        .eg_counter_out(eg_counter_out6), .eg_state_out(eg_state_out6), .eg_level_out(eg_level_out6),
        .level_valid(level_valid6), .level_ch(level_ch6), .level(level6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple envelope step logic with instant attack (AR=0): returns {counter, state, level}
    function automatic logic [26:0] step_fn(input logic on, input logic rel, input logic off,
                                            input logic [15:0] c, input logic [2:0] s, input logic [7:0] l);
        if (off)                return {16'd0, 3'd0, 8'd0};
        else if (on)            return {16'd0, 3'd1, 8'd128};
        else if (rel)           return {16'd0, 3'd4, l};
        else if (s == 3'd0)     return {c, s, l};
        else if (s == 3'd4)     return (l <= 8'd1) ? {16'd0, 3'd0, 8'd0} : {c + 16'd1, 3'd4, l - 8'd1};
        else                    return {c + 16'd1, s, l};
    endfunction

    always_comb {eg_counter_out, eg_state_out, eg_level_out} =
        step_fn(eg_key_on, eg_key_release, eg_key_off, eg_counter_in, eg_state_in, eg_level_in);
    always_comb {eg_counter_out6, eg_state_out6, eg_level_out6} =
        step_fn(eg_key_on6, eg_key_rel6, eg_key_off6, eg_counter_in6, eg_state_in6, eg_level_in6);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i] = '0; m_st[i] = '0; m_lvl[i] = '0;
        end
        m_pon = '0; m_prel = '0; m_poff = '0; m_slot = '0;
        sb.delete();
        m6_pon = '0; m6_slot = '0;
        sb6.delete();
    endtask

    // One cycle on the 8-channel instance with scoreboard push/pop
    task automatic drive(input logic en, input logic on, input logic rel, input logic off, input logic [2:0] ch);
        logic [26:0] nxt;
        logic [10:0] exp_item;
        @(negedge clk);
        slot_en = en; key_on_req = on; key_release_req = rel; key_off_req = off; key_ch = ch;
        #1;
        if (on)  begin m_pon[ch] = 1'b1; m_prel[ch] = 1'b0; end
        if (rel) m_prel[ch] = 1'b1;
        if (off) begin m_poff[ch] = 1'b1; m_pon[ch] = 1'b0; m_prel[ch] = 1'b0; end
        check_eq("eg_channel",     eg_channel,     m_slot);
        check_eq("eg_counter_in",  eg_counter_in,  m_cnt[m_slot]);
        check_eq("eg_state_in",    eg_state_in,    m_st[m_slot]);
        check_eq("eg_level_in",    eg_level_in,    m_lvl[m_slot]);
        check_eq("eg_key_on",      eg_key_on,      en & m_pon[m_slot]);
        check_eq("eg_key_release", eg_key_release, en & m_prel[m_slot]);
        check_eq("eg_key_off",     eg_key_off,     en & m_poff[m_slot]);
        if (en) begin
            nxt = step_fn(m_pon[m_slot], m_prel[m_slot], m_poff[m_slot],
                          m_cnt[m_slot], m_st[m_slot], m_lvl[m_slot]);
            {m_cnt[m_slot], m_st[m_slot], m_lvl[m_slot]} = nxt;
            m_pon[m_slot] = 1'b0; m_prel[m_slot] = 1'b0; m_poff[m_slot] = 1'b0;
            sb.push_back({m_slot, nxt[7:0]});
            m_slot = (m_slot == 3'd7) ? 3'd0 : m_slot + 3'd1;
        end
        @(posedge clk);
        #1;
        check_eq("level_valid", level_valid, en);
        if (level_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 1, 0);
            end else begin
                exp_item = sb.pop_front();
                check_eq("level_ch", level_ch, exp_item[10:8]);
                check_eq("level",    level,    exp_item[7:0]);
            end
        end
    endtask

    task automatic advance_to(input logic [2:0] target);
        for (int i = 0; i < 8 && m_slot != target; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // One cycle on the 6-channel instance: only key-on events and slot order are tracked
    task automatic drive6(input logic on, input logic [2:0] ch);
        @(negedge clk);
        slot_en6 = 1'b1; key_on6 = on; key_rel6 = 1'b0; key_off6 = 1'b0; key_ch6 = ch;
        #1;
        if (on && ch < 3'd6) m6_pon[ch] = 1'b1;
        check_eq("eg_channel6", eg_channel6, m6_slot);
        check_eq("eg_key_on6",  eg_key_on6,  m6_pon[m6_slot]);
        m6_pon[m6_slot] = 1'b0;
        sb6.push_back(m6_slot);
        m6_slot = (m6_slot == 3'd5) ? 3'd0 : m6_slot + 3'd1;
        @(posedge clk);
        #1;
        check_eq("level_valid6", level_valid6, 1);
        if (sb6.size() != 0) check_eq("level_ch6", level_ch6, sb6.pop_front());
    endtask

    initial begin
        nreset = 1'b0;
        slot_en = 0; key_on_req = 0; key_release_req = 0; key_off_req = 0; key_ch = 0;
        slot_en6 = 0; key_on6 = 0; key_rel6 = 0; key_off6 = 0; key_ch6 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_level_valid", level_valid, 0);
        check_eq("rst_eg_channel",  eg_channel,  0);
        nreset = 1'b1;

        // Idle passes: everything zero, level_ch cycles
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // Key-on ch2 requested while slot 5 is serviced
        advance_to(3'd5);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        advance_to(3'd2);
        check_eq("t2_key_on_at_slot2", eg_key_on, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_eq("t2_level_ch", level_ch, 2);
        check_eq("t2_level", level, 128);
        advance_to(3'd2);
        check_eq("t2_state", eg_state_in, 1);
        check_eq("t2_no_repeat", eg_key_on, 0);

        // Key-on ch3 in the same cycle slot 3 is serviced
        advance_to(3'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        advance_to(3'd3);
        check_eq("t3_no_double", eg_key_on, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // ch1 keyed on, then release followed by off before its slot
        advance_to(3'd4);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
        advance_to(3'd6);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        advance_to(3'd1);
        check_eq("t4_key_off", eg_key_off, 1);
        check_eq("t4_key_rel", eg_key_release, 0);
        check_eq("t4_key_on",  eg_key_on, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_eq("t4_level", level, 0);

        // All three requests in one cycle: off dominates
        advance_to(3'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
        advance_to(3'd4);
        check_eq("t4b_off_wins", {eg_key_on, eg_key_release, eg_key_off}, 3'b001);

        // slot_en low for 10 cycles with a key-on for ch0
        advance_to(3'd6);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        check_eq("t5_slot_frozen", eg_channel, 6);
        advance_to(3'd0);
        check_eq("t5_key_on_ch0", eg_key_on, 1);

        // Random traffic
        for (int i = 0; i < 120; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)));

        // Mid-pass reset with pending events and non-zero levels
        advance_to(3'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
        @(negedge clk);
        slot_en = 0; key_on_req = 0; key_release_req = 0; key_off_req = 0;
        nreset = 1'b0;
        #1;
        check_eq("mrst_eg_channel",  eg_channel,    0);
        check_eq("mrst_counter_in",  eg_counter_in, 0);
        check_eq("mrst_state_in",    eg_state_in,   0);
        check_eq("mrst_level_in",    eg_level_in,   0);
        check_eq("mrst_level_valid", level_valid,   0);
        check_eq("mrst_level_ch",    level_ch,      0);
        check_eq("mrst_level",       level,         0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_eq("sb_drained", sb.size(), 0);

        // 6-channel instance: out-of-range channels ignored, slot wraps 5->0
        for (int i = 0; i < 14; i++) drive6(1'b1, (i % 2 == 0) ? 3'd7 : 3'd6);
        drive6(1'b1, 3'd3);
        for (int i = 0; i < 13; i++) drive6(1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
